// File: rtl/cvita_cmd_pkg.sv
// cvita_cmd_pkg: shared definitions for CVITA control endpoints.
//   - CVITA packet type codes and header field offsets
//   - Response length and readback-timeout payload constants
//   - cvita_hdr_t header struct with pack/unpack helpers
//   - Command responder FSM state type
package cvita_cmd_pkg;

    localparam logic [1:0] CVITA_TYPE_CMD  = 2'b10;
    localparam logic [1:0] CVITA_TYPE_RESP = 2'b11;

    localparam int unsigned HDR_TYPE_LSB     = 62;
    localparam int unsigned HDR_HAS_TIME_BIT = 61;
    localparam int unsigned HDR_EOB_BIT      = 60;
    localparam int unsigned HDR_SEQNUM_LSB   = 48;
    localparam int unsigned HDR_LEN_LSB      = 32;
    localparam int unsigned HDR_SRC_LSB      = 16;
    localparam int unsigned HDR_DST_LSB      = 0;

    localparam logic [15:0] RESP_LEN_BYTES     = 16'd16;
    localparam logic [63:0] RB_TIMEOUT_PAYLOAD = 64'hDEAD_DEAD_DEAD_DEAD;

    typedef struct packed {
        logic [1:0]  pkt_type;
        logic        has_time;
        logic        eob;
        logic [11:0] seqnum;
        logic [15:0] length;
        logic [15:0] src_sid;
        logic [15:0] dst_sid;
    } cvita_hdr_t;

    typedef enum logic [2:0] {
        StHead,
        StTime,
        StData,
        StDrop,
        StRbWait,
        StRespHead,
        StRespData,
        StErrResp
    } cmd_state_e;

    function automatic cvita_hdr_t cvita_hdr_unpack(input logic [63:0] w);
        cvita_hdr_t h;
        h.pkt_type = w[HDR_TYPE_LSB +: 2];
        h.has_time = w[HDR_HAS_TIME_BIT];
        h.eob      = w[HDR_EOB_BIT];
        h.seqnum   = w[HDR_SEQNUM_LSB +: 12];
        h.length   = w[HDR_LEN_LSB +: 16];
        h.src_sid  = w[HDR_SRC_LSB +: 16];
        h.dst_sid  = w[HDR_DST_LSB +: 16];
        return h;
    endfunction

    function automatic logic [63:0] cvita_hdr_pack(input cvita_hdr_t h);
        logic [63:0] w;
        w = '0;
        w[HDR_TYPE_LSB +: 2]    = h.pkt_type;
        w[HDR_HAS_TIME_BIT]     = h.has_time;
        w[HDR_EOB_BIT]          = h.eob;
        w[HDR_SEQNUM_LSB +: 12] = h.seqnum;
        w[HDR_LEN_LSB +: 16]    = h.length;
        w[HDR_SRC_LSB +: 16]    = h.src_sid;
        w[HDR_DST_LSB +: 16]    = h.dst_sid;
        return w;
    endfunction

endpackage

// File: rtl/cvita_resp_hdr_gen.sv
// cvita_resp_hdr_gen: combinational CVITA response header builder.
// Ports:
//   seqnum_i       - sequence number echoed from the command
//   cmd_src_sid_i  - command source SID (becomes response destination)
//   cmd_dst_sid_i  - command destination SID (becomes response source)
//   err_i          - error flag, placed in the eob/error bit
//   hdr_o          - 64-bit response header word
module cvita_resp_hdr_gen
    import cvita_cmd_pkg::*;
(
    input  logic [11:0] seqnum_i,
    input  logic [15:0] cmd_src_sid_i,
    input  logic [15:0] cmd_dst_sid_i,
    input  logic        err_i,
    output logic [63:0] hdr_o
);

    cvita_hdr_t hdr;

    always_comb begin
        hdr.pkt_type = CVITA_TYPE_RESP;
        hdr.has_time = 1'b0;
        hdr.eob      = err_i;
        hdr.seqnum   = seqnum_i;
        hdr.length   = RESP_LEN_BYTES;
        hdr.src_sid  = cmd_dst_sid_i;
        hdr.dst_sid  = cmd_src_sid_i;
    end

    assign hdr_o = cvita_hdr_pack(hdr);

endmodule

// File: rtl/cvita_cmd_responder.sv
// cvita_cmd_responder: CVITA command sink. Parses one command packet, issues one
// settings-bus write, waits for readback data and returns one two-word response.
// Optional feature: define CVITA_CMD_RB_TIMEOUT_EN to return an error response
// after RB_TIMEOUT readback-wait cycles; otherwise the wait is unbounded.
// Ports:
//   clk, reset                        - clock, synchronous active-high reset
//   i_tdata/i_tlast/i_tvalid/i_tready - command stream in
//   o_tdata/o_tlast/o_tvalid/o_tready - response stream out
//   set_stb/set_addr/set_data         - settings-bus write
//   set_time/set_has_time             - command timestamp (0 when untimed)
//   rb_addr/rb_stb/rb_data            - readback bus
module cvita_cmd_responder
    import cvita_cmd_pkg::*;
#(
    parameter int unsigned SR_AWIDTH  = 8,
    parameter int unsigned RB_AWIDTH  = 8,
    parameter int unsigned RB_TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [63:0]          i_tdata,
    input  logic                 i_tlast,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    output logic [63:0]          o_tdata,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    output logic                 set_stb,
    output logic [SR_AWIDTH-1:0] set_addr,
    output logic [31:0]          set_data,
    output logic [63:0]          set_time,
    output logic                 set_has_time,
    output logic [RB_AWIDTH-1:0] rb_addr,
    input  logic                 rb_stb,
    input  logic [63:0]          rb_data
);

    cmd_state_e           state_q;
    logic [11:0]          seqnum_q;
    logic [15:0]          src_sid_q;
    logic [15:0]          dst_sid_q;
    logic                 err_q;
    logic                 drop_cmd_q;  // drop remainder of a valid command, then await readback
    logic [63:0]          payload_q;
    logic [63:0]          o_tdata_q;
    logic                 o_tvalid_q;
    logic                 o_tlast_q;
    logic                 set_stb_q;
    logic [SR_AWIDTH-1:0] set_addr_q;
    logic [31:0]          set_data_q;
    logic [63:0]          set_time_q;
    logic                 set_has_time_q;
    logic [RB_AWIDTH-1:0] rb_addr_q;

    logic        in_xfer;
    logic        tmo_hit;
    logic        resp_err;
    logic [63:0] resp_hdr;

    assign i_tready = !reset && (state_q inside {StHead, StTime, StData, StDrop});
    assign in_xfer  = i_tvalid && i_tready;
    assign resp_err = err_q || tmo_hit;

`ifdef CVITA_CMD_RB_TIMEOUT_EN
    localparam int unsigned TmoW = ($clog2(RB_TIMEOUT + 1) > 10) ? $clog2(RB_TIMEOUT + 1) : 10;
    logic [TmoW-1:0] tmo_cnt_q;

    // Held at zero outside the wait state, so every entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (reset || state_q != StRbWait) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
        end
    end

    assign tmo_hit = (state_q == StRbWait) && (tmo_cnt_q == TmoW'(RB_TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    cvita_resp_hdr_gen u_resp_hdr_gen (
        .seqnum_i      (seqnum_q),
        .cmd_src_sid_i (src_sid_q),
        .cmd_dst_sid_i (dst_sid_q),
        .err_i         (resp_err),
        .hdr_o         (resp_hdr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StHead;
            seqnum_q       <= '0;
            src_sid_q      <= '0;
            dst_sid_q      <= '0;
            err_q          <= 1'b0;
            drop_cmd_q     <= 1'b0;
            payload_q      <= '0;
            o_tdata_q      <= '0;
            o_tvalid_q     <= 1'b0;
            o_tlast_q      <= 1'b0;
            set_stb_q      <= 1'b0;
            set_addr_q     <= '0;
            set_data_q     <= '0;
            set_time_q     <= '0;
            set_has_time_q <= 1'b0;
            rb_addr_q      <= '0;
        end else begin
            set_stb_q <= 1'b0;
            unique case (state_q)
                StHead: begin
                    if (in_xfer) begin
                        if (i_tdata[HDR_TYPE_LSB +: 2] != CVITA_TYPE_CMD) begin
                            drop_cmd_q <= 1'b0;
                            if (!i_tlast) state_q <= StDrop;
                        end else begin
                            seqnum_q       <= i_tdata[HDR_SEQNUM_LSB +: 12];
                            src_sid_q      <= i_tdata[HDR_SRC_LSB +: 16];
                            dst_sid_q      <= i_tdata[HDR_DST_LSB +: 16];
                            set_has_time_q <= i_tdata[HDR_HAS_TIME_BIT];
                            set_time_q     <= '0;
                            err_q          <= 1'b0;
                            if (i_tlast) begin
                                err_q   <= 1'b1;
                                state_q <= StErrResp;
                            end else if (i_tdata[HDR_HAS_TIME_BIT]) begin
                                state_q <= StTime;
                            end else begin
                                state_q <= StData;
                            end
                        end
                    end
                end
                StTime: begin
                    if (in_xfer) begin
                        set_time_q <= i_tdata;
                        if (i_tlast) begin
                            err_q   <= 1'b1;
                            state_q <= StErrResp;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (in_xfer) begin
                        set_addr_q <= i_tdata[32 +: SR_AWIDTH];
                        set_data_q <= i_tdata[31:0];
                        rb_addr_q  <= i_tdata[32 +: RB_AWIDTH];
                        set_stb_q  <= 1'b1;
                        if (i_tlast) begin
                            state_q <= StRbWait;
                        end else begin
                            drop_cmd_q <= 1'b1;
                            state_q    <= StDrop;
                        end
                    end
                end
                StDrop: begin
                    if (in_xfer && i_tlast) state_q <= drop_cmd_q ? StRbWait : StHead;
                end
                StRbWait: begin
                    // Readback coinciding with the write strobe predates the write.
                    if (rb_stb && !set_stb_q) begin
                        payload_q  <= rb_data;
                        o_tdata_q  <= resp_hdr;
                        o_tvalid_q <= 1'b1;
                        state_q    <= StRespHead;
                    end else if (tmo_hit) begin
                        err_q      <= 1'b1;
                        payload_q  <= RB_TIMEOUT_PAYLOAD;
                        o_tdata_q  <= resp_hdr;
                        o_tvalid_q <= 1'b1;
                        state_q    <= StRespHead;
                    end
                end
                StErrResp: begin
                    payload_q  <= '0;
                    o_tdata_q  <= resp_hdr;
                    o_tvalid_q <= 1'b1;
                    state_q    <= StRespHead;
                end
                StRespHead: begin
                    if (o_tready) begin
                        o_tdata_q <= payload_q;
                        o_tlast_q <= 1'b1;
                        state_q   <= StRespData;
                    end
                end
                StRespData: begin
                    if (o_tready) begin
                        o_tdata_q  <= '0;
                        o_tvalid_q <= 1'b0;
                        o_tlast_q  <= 1'b0;
                        state_q    <= StHead;
                    end
                end
                default: state_q <= StHead;
            endcase
        end
    end

    assign o_tdata      = o_tdata_q;
    assign o_tvalid     = o_tvalid_q;
    assign o_tlast      = o_tlast_q;
    assign set_stb      = set_stb_q;
    assign set_addr     = set_addr_q;
    assign set_data     = set_data_q;
    assign set_time     = set_time_q;
    assign set_has_time = set_has_time_q;
    assign rb_addr      = rb_addr_q;

endmodule

// File: tb/tb_cvita_cmd_responder.sv
// tb_cvita_cmd_responder: directed self-checking bench for cvita_cmd_responder.
// Inputs change 1ns after the rising edge; DUT outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_cvita_cmd_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [63:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [63:0] set_time;
    logic        set_has_time;
    logic [7:0]  rb_addr;
    logic        rb_stb;
    logic [63:0] rb_data;

    always #5 clk = ~clk;

    cvita_cmd_responder #(
        .SR_AWIDTH  (8),
        .RB_AWIDTH  (8),
        .RB_TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_tdata      (i_tdata),
        .i_tlast      (i_tlast),
        .i_tvalid     (i_tvalid),
        .i_tready     (i_tready),
        .o_tdata      (o_tdata),
        .o_tlast      (o_tlast),
        .o_tvalid     (o_tvalid),
        .o_tready     (o_tready),
        .set_stb      (set_stb),
        .set_addr     (set_addr),
        .set_data     (set_data),
        .set_time     (set_time),
        .set_has_time (set_has_time),
        .rb_addr      (rb_addr),
        .rb_stb       (rb_stb),
        .rb_data      (rb_data)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor state (written only by the monitor process)
    int          cyc = 0;
    int          stb_cnt = 0;
    int          stb_cyc = 0;
    int          tv_rise_cyc = 0;
    logic        prev_tv = 1'b0;
    logic [63:0] cap_addr, cap_data, cap_time;
    logic        cap_ht;
    logic [63:0] rq_data[$];
    logic        rq_last[$];

    int rd_idx = 0;
    int base;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (set_stb) begin
                stb_cnt  = stb_cnt + 1;
                stb_cyc  = cyc;
                cap_addr = 64'(set_addr);
                cap_data = 64'(set_data);
                cap_time = set_time;
                cap_ht   = set_has_time;
            end
            if (o_tvalid && !prev_tv) tv_rise_cyc = cyc;
            if (o_tvalid && o_tready) begin
                rq_data.push_back(o_tdata);
                rq_last.push_back(o_tlast);
            end
        end
        prev_tv = o_tvalid;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entered and left 1ns after a rising edge.
    task automatic send_word(input logic [63:0] d, input logic last);
        int n = 0;
        i_tdata  = d;
        i_tlast  = last;
        i_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (i_tready) break;
            n++;
            if (n > 200) begin
                check("send_ready", 64'(i_tready), 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic collect_resp(input string tag, input logic [63:0] exp_hdr,
                                input logic [63:0] exp_pay);
        int n = 0;
        while (rq_data.size() < rd_idx + 2 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (rq_data.size() < rd_idx + 2) begin
            check({tag, "_resp_words"}, 64'(rq_data.size() - rd_idx), 64'd2);
            rd_idx = rq_data.size();
        end else begin
            check({tag, "_hdr"},   rq_data[rd_idx],         exp_hdr);
            check({tag, "_last0"}, 64'(rq_last[rd_idx]),     64'd0);
            check({tag, "_pay"},   rq_data[rd_idx + 1],     exp_pay);
            check({tag, "_last1"}, 64'(rq_last[rd_idx + 1]), 64'd1);
            rd_idx += 2;
        end
    endtask

    initial begin
        reset    = 1'b1;
        i_tdata  = '0;
        i_tlast  = 1'b0;
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        rb_stb   = 1'b0;
        rb_data  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_i_tready", 64'(i_tready), 64'd0);
        check("rst_flags", {59'd0, o_tvalid, o_tlast, set_stb, set_has_time, 1'b0}, 64'd0);
        check("rst_o_tdata", o_tdata, 64'd0);
        check("rst_set", {set_addr, set_data, rb_addr, 16'd0}, 64'd0);
        check("rst_set_time", set_time, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_i_tready", 64'(i_tready), 64'd1);
        @(posedge clk);
        #1;

        // 1: untimed command
        base    = stb_cnt;
        rb_stb  = 1'b1;
        rb_data = 64'h1234;
        send_word(64'h8000_0010_0002_0001, 1'b0);
        send_word({32'h0000_0005, 32'hCAFE_F00D}, 1'b1);
        collect_resp("t1", 64'hC000_0010_0001_0002, 64'h1234);
        check("t1_stb_cnt", 64'(stb_cnt - base), 64'd1);
        check("t1_addr", cap_addr, 64'h5);
        check("t1_data", cap_data, 64'hCAFE_F00D);
        check("t1_has_time", 64'(cap_ht), 64'd0);
        check("t1_time", cap_time, 64'd0);
        check("t1_rb_addr", 64'(rb_addr), 64'h5);
        check("t1_latency", 64'(tv_rise_cyc - stb_cyc), 64'd2);

        // 2: timed command
        base    = stb_cnt;
        rb_data = 64'h5555;
        send_word(64'hAABC_0018_0010_0020, 1'b0);
        send_word(64'd1000, 1'b0);
        send_word({32'h0000_0012, 32'h1111_2222}, 1'b1);
        collect_resp("t2", 64'hCABC_0010_0020_0010, 64'h5555);
        check("t2_stb_cnt", 64'(stb_cnt - base), 64'd1);
        check("t2_time", cap_time, 64'd1000);
        check("t2_has_time", 64'(cap_ht), 64'd1);
        check("t2_addr", cap_addr, 64'h12);

        // 3: non-command packet dropped, then a valid command
        base = stb_cnt;
        send_word(64'h0000_0018_0002_0001, 1'b0);
        send_word(64'h1111_1111_1111_1111, 1'b0);
        send_word(64'h2222_2222_2222_2222, 1'b1);
        idle(5);
        check("t3_drop_stb", 64'(stb_cnt - base), 64'd0);
        check("t3_drop_resp", 64'(rq_data.size() - rd_idx), 64'd0);
        rb_data = 64'h77;
        send_word(64'h8005_0010_0003_0004, 1'b0);
        send_word({32'h0000_00A0, 32'hDEAD_BEEF}, 1'b1);
        collect_resp("t3", 64'hC005_0010_0004_0003, 64'h77);
        check("t3_stb_cnt", 64'(stb_cnt - base), 64'd1);
        check("t3_addr", cap_addr, 64'hA0);

        // 4: truncated command
        base = stb_cnt;
        send_word(64'h8007_0010_0002_0001, 1'b1);
        collect_resp("t4", 64'hD007_0010_0001_0002, 64'd0);
        check("t4_stb_cnt", 64'(stb_cnt - base), 64'd0);

        // 5: response back-pressure
        base     = stb_cnt;
        o_tready = 1'b0;
        rb_data  = 64'h99;
        send_word(64'h8009_0010_0002_0001, 1'b0);
        send_word({32'h0000_0003, 32'h0BAD_F00D}, 1'b1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_tvalid) break;
        end
        check("t5_valid", 64'(o_tvalid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t5_stall_data%0d", i), o_tdata, 64'hC009_0010_0001_0002);
            check($sformatf("t5_stall_rdy%0d", i), {62'd0, i_tready, o_tvalid}, 64'd1);
        end
        @(posedge clk);
        #1;
        o_tready = 1'b1;
        collect_resp("t5", 64'hC009_0010_0001_0002, 64'h99);
        check("t5_stb_cnt", 64'(stb_cnt - base), 64'd1);

        // 6: readback never arrives
        base   = stb_cnt;
        rb_stb = 1'b0;
        send_word(64'h800E_0010_0002_0001, 1'b0);
        send_word({32'h0000_0007, 32'h0000_0001}, 1'b1);
`ifdef CVITA_CMD_RB_TIMEOUT_EN
        collect_resp("t6", 64'hD00E_0010_0001_0002, 64'hDEAD_DEAD_DEAD_DEAD);
`else
        idle(100);
        check("t6_no_resp", 64'(rq_data.size() - rd_idx), 64'd0);
        @(negedge clk);
        check("t6_waiting", {62'd0, i_tready, o_tvalid}, 64'd0);
        @(posedge clk);
        #1;
`endif
        check("t6_stb_cnt", 64'(stb_cnt - base), 64'd1);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        @(negedge clk);
        check("t6_post_rst", {62'd0, i_tready, o_tvalid}, 64'd2);
        @(posedge clk);
        #1;

        // 7: reset in the middle of a command, then a normal command
        base    = stb_cnt;
        rb_stb  = 1'b1;
        rb_data = 64'hAA;
        send_word(64'h800F_0010_0002_0001, 1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        send_word(64'h8010_0010_0002_0001, 1'b0);
        send_word({32'h0000_0009, 32'h0000_0002}, 1'b1);
        collect_resp("t7", 64'hC010_0010_0001_0002, 64'hAA);
        check("t7_stb_cnt", 64'(stb_cnt - base), 64'd1);
        check("t7_addr", cap_addr, 64'h9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
